// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Purpose:
//   Conditions four raw, asynchronous, active-high push buttons (up, down,
//   left, right) into clean signals for the downstream VGA block. Each button
//   is synchronized with two flops and debounced by its own four-state FSM.
//   The FSM produces a steady pressed level and a one-cycle strobe for every
//   accepted press.
//
// Optional feature (compile-time macro):
//   BTN_AUTO_REPEAT_EN - when defined, a held button also produces repeat
//   strobes. The first comes REPEAT_DELAY cycles after the initial strobe.
//   Later ones follow every REPEAT_PERIOD cycles while the button stays held.
//   When the macro is undefined, no repeat logic exists and each accepted
//   press gives exactly one strobe.
//
// Parameters:
//   DEBOUNCE_CYCLES - stable synchronized samples needed to accept an edge
//   REPEAT_DELAY    - cycles from initial strobe to first repeat strobe
//   REPEAT_PERIOD   - cycles between later repeat strobes
//   CNT_WIDTH       - width of every per-channel counter
//
// Ports:
//   sys_clk    in   sole clock, all state updates on the rising edge
//   sys_rst_n  in   synchronous active-low reset
//   btn_in     in   [3:0] raw buttons, bit0=up bit1=down bit2=left bit3=right
//   btn_level  out  [3:0] debounced pressed state, registered
//   btn_pulse  out  [3:0] one-cycle press/repeat strobe, registered
// -----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_WIDTH       = 25
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] btn_in,
    output logic [3:0] btn_level,
    output logic [3:0] btn_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_e;

    // Terminal value of the debounce counter. The counter stops here, so it
    // can never wrap.
    localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_WIDTH-1:0] RPT_DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] RPT_PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);
`endif

    // Refuse to elaborate with counts that cannot be represented. Otherwise a
    // too-narrow counter would silently truncate the terminal compare value.
    if (DEBOUNCE_CYCLES < 1 || (DEBOUNCE_CYCLES >> CNT_WIDTH) != 0 ||
        REPEAT_DELAY < 1    || (REPEAT_DELAY >> CNT_WIDTH) != 0 ||
        REPEAT_PERIOD < 1   || (REPEAT_PERIOD >> CNT_WIDTH) != 0) begin : g_badParams
        $error("btn_conditioner: illegal DEBOUNCE/REPEAT/CNT_WIDTH combination");
    end

    logic [3:0] syncMeta_q;
    logic [3:0] syncOut_q;

    // Two-flop synchronizer for each button. Only the second stage feeds the
    // channel FSMs. Reset clears both stages, so a button that is still held
    // after reset is seen as a fresh rising edge with full debounce latency.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            syncMeta_q <= 4'b0000;
            syncOut_q  <= 4'b0000;
        end else begin
            syncMeta_q <= btn_in;
            syncOut_q  <= syncMeta_q;
        end
    end

    for (genvar ch = 0; ch < 4; ch++) begin : g_chan
        state_e               state_q;
        logic [CNT_WIDTH-1:0] debCnt_q;
        logic                 level_q;
        logic                 pulse_q;
        logic                 syncBit;
`ifdef BTN_AUTO_REPEAT_EN
        logic [CNT_WIDTH-1:0] rptCnt_q;
        logic                 rptFirst_q;
`endif

        assign syncBit = syncOut_q[ch];

        // Per-channel debounce FSM. It accepts a press or a release only after
        // DEBOUNCE_CYCLES consecutive equal samples. A short excursion sends
        // the channel back to its previous stable state without any output.
        // The strobe defaults low every cycle, so it can only ever be a
        // single-cycle pulse. With auto-repeat enabled, the repeat counter
        // advances only in HELD. It keeps its value across a bounce through
        // RELEASE_WAIT and is cleared when the channel returns to IDLE.
        always_ff @(posedge sys_clk) begin
            if (!sys_rst_n) begin
                state_q    <= IDLE;
                debCnt_q   <= '0;
                level_q    <= 1'b0;
                pulse_q    <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
                rptCnt_q   <= '0;
                rptFirst_q <= 1'b1;
`endif
            end else begin
                pulse_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (syncBit) begin
                            state_q  <= PRESS_WAIT;
                            debCnt_q <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!syncBit) begin
                            state_q <= IDLE;
                        end else if (debCnt_q == DEB_LAST) begin
                            state_q    <= HELD;
                            level_q    <= 1'b1;
                            pulse_q    <= 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                            rptCnt_q   <= '0;
                            rptFirst_q <= 1'b1;
`endif
                        end else begin
                            debCnt_q <= debCnt_q + 1'b1;
                        end
                    end
                    HELD: begin
                        // A release in progress takes priority over a
                        // repeat strobe that falls due in the same cycle.
                        if (!syncBit) begin
                            state_q  <= RELEASE_WAIT;
                            debCnt_q <= '0;
                        end
`ifdef BTN_AUTO_REPEAT_EN
                        else if (rptCnt_q == (rptFirst_q ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
                            pulse_q    <= 1'b1;
                            rptCnt_q   <= '0;
                            rptFirst_q <= 1'b0;
                        end else begin
                            rptCnt_q <= rptCnt_q + 1'b1;
                        end
`endif
                    end
                    RELEASE_WAIT: begin
                        if (syncBit) begin
                            state_q <= HELD;
                        end else if (debCnt_q == DEB_LAST) begin
                            state_q    <= IDLE;
                            level_q    <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
                            rptCnt_q   <= '0;
                            rptFirst_q <= 1'b1;
`endif
                        end else begin
                            debCnt_q <= debCnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end

        assign btn_level[ch] = level_q;
        assign btn_pulse[ch] = pulse_q;
    end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples needed to accept a press or release (20 ms at 50 MHz); legal range 1 to 2^CNT_WIDTH-1.
REQ-002 Parameter REPEAT_DELAY, 25000000, cycles from the initial press pulse to the first repeat pulse; legal range >=1.
REQ-003 Parameter REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses; legal range >=1.
REQ-004 Parameter CNT_WIDTH, 25, width of every per-channel counter; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).
REQ-005 sys_clk  input  1  sole clock, 50 MHz, all state on rising edge.
REQ-006 sys_rst_n  input  1  reset, synchronous, active-low.
REQ-007 btn_in  input  4  raw asynchronous buttons, active-high; bit0=up, bit1=down, bit2=left, bit3=right.
REQ-008 btn_level  output  4  debounced pressed state per channel, registered.
REQ-009 btn_pulse  output  4  one-cycle press/repeat strobe per channel, registered; drives the up/down/left/right inputs of the downstream VGA block.

Function
REQ-010 Each btn_in bit SHALL pass through a private 2-flop synchronizer; only the second-flop value (s) feeds channel logic.
REQ-011 The four channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own outputs in the same cycle.
REQ-012 Per-channel FSM states SHALL be IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-013 IDLE: s=1 -> PRESS_WAIT with debounce counter cleared to 0; else stay.
REQ-014 PRESS_WAIT: s=0 -> IDLE (glitch rejected, no output); s=1 and counter==DEBOUNCE_CYCLES-1 -> HELD, btn_level<=1, btn_pulse<=1 for one cycle; else counter+1.
REQ-015 Net press latency: btn_pulse and btn_level registered high on edge DEBOUNCE_CYCLES+2, counting the edge that first samples btn_in high as edge 0; a high excursion shorter than DEBOUNCE_CYCLES+1 edges SHALL never produce output.
REQ-016 HELD: s=0 -> RELEASE_WAIT with debounce counter cleared; else stay.
REQ-017 RELEASE_WAIT: s=1 -> HELD (no output change); s=0 and counter==DEBOUNCE_CYCLES-1 -> IDLE, btn_level<=0; else counter+1; release SHALL never generate btn_pulse.
REQ-018 btn_pulse SHALL be high for exactly one cycle per event and low in every other cycle.
REQ-019 Counters SHALL never wrap; each is cleared or held at its terminal compare value.

Reset
REQ-020 sys_rst_n low at a rising edge SHALL force all channels to IDLE, clear all counters and synchronizer flops, btn_level=4'b0000, btn_pulse=4'b0000.
REQ-021 Reset asserted mid-press or mid-repeat SHALL abort without a pulse; after release a held button SHALL be treated as a fresh press (full debounce latency, new initial pulse).

Configuration
REQ-022 Macro BTN_AUTO_REPEAT_EN defined: in HELD a repeat counter SHALL run, issuing a btn_pulse REPEAT_DELAY cycles after the initial pulse and every REPEAT_PERIOD cycles thereafter while in HELD.
REQ-023 With BTN_AUTO_REPEAT_EN: repeat counter SHALL hold its value during RELEASE_WAIT, resume on return to HELD, and clear on entry to IDLE; no repeat pulse SHALL issue outside HELD.
REQ-024 Macro undefined: no repeat counter SHALL be synthesized; exactly one btn_pulse per accepted press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, CNT_WIDTH=8)
REQ-025 Reset then btn_in=4'b0001 held from edge 0 -> btn_pulse=4'b0001 for one cycle and btn_level[0]=1 at edge 6; no other bits change.
REQ-026 btn_in[2] high for 3 edges then low -> btn_level and btn_pulse remain 0 for 20 cycles.
REQ-027 Held channel 1, btn_in[1] low 2 edges then high -> btn_level[1] stays 1, no pulse; btn_in[1] low 6+ edges -> btn_level[1]=0 at edge 6 after the first low sample, no pulse.
REQ-028 BTN_AUTO_REPEAT_EN defined, btn_in[3] held 60 cycles -> pulses at edges 6, 26, 34, 42, 50, 58; macro undefined -> single pulse at edge 6.
REQ-029 btn_in=4'b1111 at edge 0 -> btn_pulse=4'b1111 at edge 6; sys_rst_n low at edge 10 -> outputs 4'b0000 at edge 10, next pulse at edge 17 after release at edge 11.
